// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem requests, in-order {pc, instr} FIFO
// Redirects flush buffered entries and drop responses to requests issued before the redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_DRAIN} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] stale;
  logic [CW-1:0] count;
  logic [AW-1:0] head;
  logic [AW-1:0] q_wptr;
  logic [AW-1:0] q_rptr;
  logic [31:0]   fifo_pc    [DEPTH];
  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   q_pc       [DEPTH];

  logic          req_fire;
  logic          push;
  logic          pop;
  logic [AW-1:0] tail;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] stale_after_redirect;
  logic [CW-1:0] stale_next;
  logic          unused;

  // Credit rule: requests in flight plus buffered entries never exceed DEPTH.
  assign imem_req_valid_o = (state == S_RUN) && !redirect_i &&
                            (({1'b0, inflight} + {1'b0, count}) < DEPTH_W);
  assign imem_req_addr_o  = fetch_pc;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;
  assign push             = imem_rsp_valid_i && (state == S_RUN) && !redirect_i && (inflight != '0);
  assign pop              = instr_valid_o && instr_ready_i;
  assign tail             = head + count[AW-1:0];

  // A response landing in the redirect cycle belongs to the old path and is dropped at once.
  assign outstanding          = inflight + stale;
  assign stale_after_redirect = outstanding - CW'(imem_rsp_valid_i && (outstanding != '0));
  assign stale_next           = stale - CW'(imem_rsp_valid_i && (stale != '0));

  assign instr_valid_o = (count != '0);
  assign instr_o       = fifo_instr[head];
  assign pc_o          = fifo_pc[head];
  assign pc_plus4_o    = fifo_pc[head] + 32'd4;
  assign unused        = ^redirect_pc_i[1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_INIT;
      fetch_pc <= RESET_PC;
      inflight <= '0;
      stale    <= '0;
      count    <= '0;
      head     <= '0;
      q_wptr   <= '0;
      q_rptr   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc[i]    <= '0;
        fifo_instr[i] <= '0;
        q_pc[i]       <= '0;
      end
    end else begin
      if (push) begin
        fifo_pc[tail]    <= q_pc[q_rptr];
        fifo_instr[tail] <= imem_rsp_data_i;
      end
      if (req_fire) q_pc[q_wptr] <= fetch_pc;
      if (pop) head <= head + AW'(1);

      if (redirect_i) begin
        fetch_pc <= {redirect_pc_i[31:2], 2'b00};
        count    <= '0;
        inflight <= '0;
        stale    <= stale_after_redirect;
        q_wptr   <= '0;
        q_rptr   <= '0;
        state    <= (stale_after_redirect != '0) ? S_DRAIN : S_RUN;
      end else begin
        count <= count + CW'(push) - CW'(pop);
        case (state)
          S_INIT: state <= S_RUN;
          S_RUN: begin
            if (req_fire) begin
              fetch_pc <= fetch_pc + 32'd4;
              q_wptr   <= q_wptr + AW'(1);
            end
            if (push) q_rptr <= q_rptr + AW'(1);
            inflight <= inflight + CW'(req_fire) - CW'(push);
          end
          S_DRAIN: begin
            stale <= stale_next;
            if (stale_next == '0) state <= S_RUN;
          end
          default: state <= S_INIT;
        endcase
      end
    end
  end

  assert property (@(posedge clk_i) disable iff (rst_i)
    (state == S_RUN && !redirect_i && imem_rsp_valid_i) |-> (inflight != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit: vector table, directed corners, random vs model
module tb_fetch_unit;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_ready = 1'b0;
  logic [31:0] req_addr;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid, instr_ready = 1'b0;
  logic [31:0] instr, pc, pc_plus4;

  logic        w_rst = 1'b1;
  logic        w_req_valid, w_req_ready = 1'b1;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid = 1'b0;
  logic [31:0] w_rsp_data = '0;
  logic        w_instr_valid;
  logic [31:0] w_instr, w_pc, w_pc_plus4;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_valid_o(req_valid), .imem_req_ready_i(req_ready), .imem_req_addr_o(req_addr),
    .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
    .instr_o(instr), .pc_o(pc), .pc_plus4_o(pc_plus4)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) dut_wrap (
    .clk_i(clk), .rst_i(w_rst),
    .imem_req_valid_o(w_req_valid), .imem_req_ready_i(w_req_ready), .imem_req_addr_o(w_req_addr),
    .imem_rsp_valid_i(w_rsp_valid), .imem_rsp_data_i(w_rsp_data),
    .redirect_i(1'b0), .redirect_pc_i(32'h0),
    .instr_valid_o(w_instr_valid), .instr_ready_i(1'b1),
    .instr_o(w_instr), .pc_o(w_pc), .pc_plus4_o(w_pc_plus4)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] addr;
    bit          live;
    int          due;
  } pend_t;

  typedef struct {
    bit          rr;
    bit          ir;
    bit          ev;
    logic [31:0] ea;
    bit          eiv;
    logic [31:0] epc;
    logic [31:0] ei;
    logic [31:0] ep4;
  } vec_t;

  pend_t       pend[$];
  logic [31:0] avail[$];
  logic [31:0] exp_pc;
  int          cyc = 0;
  int          since_rst = 0;
  bit          lat_rand = 0;

  bit          s_rv, s_iv;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_42B7;
      32'h0000_0004: return 32'h0000_B317;
      32'h0000_0008: return 32'h0080_056F;
      default:       return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endcase
  endfunction

  function automatic int n_live();
    int n = 0;
    foreach (pend[i]) if (pend[i].live) n++;
    return n;
  endfunction

  function automatic int n_stale();
    int n = 0;
    foreach (pend[i]) if (!pend[i].live) n++;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1; req_ready = 1'b0; instr_ready = 1'b0; redirect = 1'b0; rsp_valid = 1'b0;
      #1;
      if (i > 0) begin
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_req_valid", {31'b0, req_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc_plus4", pc_plus4, 32'h4);
      end
    end
    pend.delete();
    avail.delete();
    exp_pc = 32'h0000_0000;
    since_rst = 0;
  endtask

  // One clock cycle: drive inputs, compare DUT against the model, then advance the model.
  task automatic step(input bit rr, input bit ir, input bit rd, input logic [31:0] rpc, input int mode);
    bit    rsp, acc, pop, exp_rv;
    int    lat;
    pend_t h;
    @(negedge clk);
    rst = 1'b0;
    rsp = 1'b0;
    if (pend.size() > 0 && pend[0].due <= cyc)
      rsp = (mode == 1) || (mode == 2 && $urandom_range(0, 1) == 1);
    req_ready = rr; instr_ready = ir; redirect = rd; redirect_pc = rpc;
    rsp_valid = rsp;
    rsp_data = rsp ? memf(pend[0].addr) : $urandom();
    #1;
    s_rv = req_valid; s_addr = req_addr; s_iv = instr_valid; s_pc = pc; s_instr = instr;

    chk("instr_valid", {31'b0, instr_valid}, {31'b0, avail.size() > 0});
    if (avail.size() > 0) begin
      chk("pc", pc, avail[0]);
      chk("instr", instr, memf(avail[0]));
      chk("pc_plus4", pc_plus4, avail[0] + 32'd4);
    end
    exp_rv = !rd && since_rst >= 1 && n_stale() == 0 && (n_live() + avail.size() < DEPTH);
    chk("req_valid", {31'b0, req_valid}, {31'b0, exp_rv});
    if (exp_rv) chk("req_addr", req_addr, exp_pc);

    acc = exp_rv && rr;
    pop = (avail.size() > 0) && ir;
    if (pop) void'(avail.pop_front());
    if (rsp) begin
      h = pend.pop_front();
      if (h.live && !rd) avail.push_back(h.addr);
    end
    if (acc) begin
      lat = lat_rand ? int'($urandom_range(0, 2)) : 0;
      pend.push_back('{addr: exp_pc, live: 1'b1, due: cyc + 1 + lat});
      exp_pc = exp_pc + 32'd4;
    end
    if (rd) begin
      foreach (pend[i]) pend[i].live = 1'b0;
      avail.delete();
      exp_pc = rpc & 32'hFFFF_FFFC;
    end
    cyc++;
    since_rst++;
  endtask

  vec_t        tbl[7];
  logic [31:0] got[$];
  bit          found;
  bit          rd;
  logic [31:0] rpc;

  initial begin
    // Wrap instance: RESET_PC at the top of the address space.
    repeat (2) @(negedge clk);
    @(negedge clk); w_rst = 1'b0; #1;
    chk("wrap_init_req_valid", {31'b0, w_req_valid}, 32'd0);
    @(negedge clk); #1;
    chk("wrap_req1_valid", {31'b0, w_req_valid}, 32'd1);
    chk("wrap_req1_addr", w_req_addr, 32'hFFFF_FFFC);
    @(negedge clk); w_rsp_valid = 1'b1; w_rsp_data = memf(32'hFFFF_FFFC); #1;
    chk("wrap_req2_valid", {31'b0, w_req_valid}, 32'd1);
    chk("wrap_req2_addr", w_req_addr, 32'h0000_0000);
    @(negedge clk); w_rsp_valid = 1'b0; #1;
    chk("wrap_instr_valid", {31'b0, w_instr_valid}, 32'd1);
    chk("wrap_pc", w_pc, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", w_pc_plus4, 32'h0000_0000);
    chk("wrap_instr", w_instr, memf(32'hFFFF_FFFC));
    @(negedge clk); w_rst = 1'b1;

    // Stream with memory latency 1 and decode always ready; credit allows two per three cycles.
    tbl[0] = '{rr:1, ir:1, ev:0, ea:32'h0, eiv:0, epc:32'h0, ei:32'h0,          ep4:32'h0};
    tbl[1] = '{rr:1, ir:1, ev:1, ea:32'h0, eiv:0, epc:32'h0, ei:32'h0,          ep4:32'h0};
    tbl[2] = '{rr:1, ir:1, ev:1, ea:32'h4, eiv:0, epc:32'h0, ei:32'h0,          ep4:32'h0};
    tbl[3] = '{rr:1, ir:1, ev:0, ea:32'h0, eiv:1, epc:32'h0, ei:32'h0000_42B7, ep4:32'h4};
    tbl[4] = '{rr:1, ir:1, ev:1, ea:32'h8, eiv:1, epc:32'h4, ei:32'h0000_B317, ep4:32'h8};
    tbl[5] = '{rr:1, ir:1, ev:1, ea:32'hC, eiv:0, epc:32'h0, ei:32'h0,          ep4:32'h0};
    tbl[6] = '{rr:1, ir:1, ev:0, ea:32'h0, eiv:1, epc:32'h8, ei:32'h0080_056F, ep4:32'hC};
    do_reset(2);
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].rr, tbl[i].ir, 1'b0, 32'h0, 1);
      chk($sformatf("tbl%0d_req_valid", i), {31'b0, s_rv}, {31'b0, tbl[i].ev});
      if (tbl[i].ev) chk($sformatf("tbl%0d_req_addr", i), s_addr, tbl[i].ea);
      chk($sformatf("tbl%0d_instr_valid", i), {31'b0, s_iv}, {31'b0, tbl[i].eiv});
      if (tbl[i].eiv) begin
        chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].epc);
        chk($sformatf("tbl%0d_instr", i), s_instr, tbl[i].ei);
        chk($sformatf("tbl%0d_pc_plus4", i), pc_plus4, tbl[i].ep4);
      end
    end

    // Backpressure: decode stalls, FIFO fills, requests stop; then 0, 4, 8 drain in order.
    do_reset(2);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1);
    chk("bp_full_req_valid", {31'b0, s_rv}, 32'd0);
    chk("bp_full_head_pc", s_pc, 32'h0);
    got.delete();
    for (int k = 0; k < 20 && got.size() < 3; k++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 1);
      if (s_iv) got.push_back(s_pc);
    end
    chk("bp_drain_count", got.size(), 32'd3);
    if (got.size() == 3) begin
      chk("bp_drain_pc0", got[0], 32'h0);
      chk("bp_drain_pc1", got[1], 32'h4);
      chk("bp_drain_pc2", got[2], 32'h8);
    end

    // Redirect with two requests in flight: both responses dropped while draining.
    do_reset(2);
    step(1'b1, 1'b0, 1'b0, 32'h0, 0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0100, 0);
    chk("redir_cycle_req_valid", {31'b0, s_rv}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1);
    chk("drain1_req_valid", {31'b0, s_rv}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1);
    chk("drain2_req_valid", {31'b0, s_rv}, 32'd0);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 1);
      if (s_iv) found = 1'b1;
    end
    chk("redir_found", {31'b0, found}, 32'd1);
    if (found) chk("redir_first_pc", s_pc, 32'h0000_0100);

    // Redirect to unaligned target together with a response and a decode handshake.
    do_reset(2);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0103, 1);
    chk("coinc_popped_valid", {31'b0, s_iv}, 32'd1);
    chk("coinc_popped_pc", s_pc, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1);
    chk("coinc_next_valid", {31'b0, s_iv}, 32'd0);
    chk("coinc_next_req_valid", {31'b0, s_rv}, 32'd1);
    chk("coinc_next_addr", s_addr, 32'h0000_0100);

    // Random traffic against the model, including wrap-around redirect targets.
    lat_rand = 1'b1;
    do_reset(2);
    for (int n = 0; n < 3000; n++) begin
      rd = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 2))
        0:       rpc = $urandom();
        1:       rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: rpc = 32'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 499) == 0) do_reset(1);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, rd, rpc, 2);
    end

    // Reset mid-stream: outputs return to reset values, fetch restarts at RESET_PC.
    do_reset(2);
    lat_rand = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
